// File: rtl/featuremap_conv2d_accum_param.sv
// featuremap_conv2d_accum_param
// Channel-accumulation stage: pops CHANNELS show-ahead FIFOs together, sums the
// samples in a pipelined signed adder tree, adds BIAS, saturates to DATA_WIDTH
// and streams one pixel per cycle with backpressure and end-of-frame marking.
// Optional build macro: FEATUREMAP_RELU_EN (clamp negative results to zero).
module featuremap_conv2d_accum_param #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 8,
    parameter int CHANNELS   = 8,
    parameter logic signed [DATA_WIDTH-1:0] BIAS = '0,
    parameter int WIDTH      = 112,
    parameter int HEIGHT     = 112
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [CHANNELS*DATA_WIDTH-1:0] data_in,
    input  logic [CHANNELS-1:0]            fifo_empty,
    output logic                           rdreq,
    input  logic                           ready_in,
    output logic                           valid_out,
    output logic [DATA_WIDTH-1:0]          data_out,
    output logic                           last_out
);

    localparam int LEVELS    = $clog2(CHANNELS);
    localparam int ACC_WIDTH = DATA_WIDTH + LEVELS + 1;
    localparam int NPAD      = 1 << LEVELS;
    // vld_pipe[0] = stage 0, vld_pipe[LEVELS] = tree root, vld_pipe[STAGES] = output
    localparam int STAGES    = LEVELS + 1;
    localparam int CW        = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int RW        = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    // The Q format only matters to the producer/consumer; reject nonsense configs.
    if (CHANNELS < 1 || FRAC_BITS < 0 || FRAC_BITS >= DATA_WIDTH) begin : g_cfg_check
        $error("featuremap_conv2d_accum_param: bad CHANNELS/FRAC_BITS");
    end

    logic                          advance;
    logic                          accept;
    logic                          hs;
    logic [STAGES:0]               vld_pipe;
    // Level 0 holds the sign-extended inputs (zero padded to a power of two);
    // level k holds NPAD>>k partial sums, the upper entries are never read.
    logic signed [ACC_WIDTH-1:0]   tree [0:LEVELS][0:NPAD-1];
    logic signed [ACC_WIDTH-1:0]   biased;
    logic [DATA_WIDTH-1:0]         sat_val;
    logic [CW-1:0]                 col, col_inc, pos_col;
    logic [RW-1:0]                 row, row_inc, pos_row;

    // Single global stall: everything moves only when the output slot frees up.
    assign advance   = ~valid_out | ready_in;
    assign accept    = advance & ~|fifo_empty & ~rst;
    assign rdreq     = accept;
    assign hs        = valid_out & ready_in;
    assign valid_out = vld_pipe[STAGES];

    // Input capture and pairwise adder tree; data registers need no reset.
    always_ff @(posedge clk) begin
        if (advance) begin
            for (int c = 0; c < CHANNELS; c++)
                tree[0][c] <= ACC_WIDTH'($signed(data_in[c*DATA_WIDTH +: DATA_WIDTH]));
            for (int c = CHANNELS; c < NPAD; c++)
                tree[0][c] <= '0;
            for (int k = 1; k <= LEVELS; k++)
                for (int i = 0; i < (NPAD >> k); i++)
                    tree[k][i] <= tree[k-1][2*i] + tree[k-1][2*i+1];
        end
    end

    assign biased = tree[LEVELS][0] + ACC_WIDTH'(BIAS);

    // Clamp the full-precision sum to the output range, then optional ReLU.
    always_comb begin
        sat_val = biased[DATA_WIDTH-1:0];
        if (biased > SAT_MAX)
            sat_val = SAT_MAX[DATA_WIDTH-1:0];
        else if (biased < SAT_MIN)
            sat_val = SAT_MIN[DATA_WIDTH-1:0];
`ifdef FEATUREMAP_RELU_EN
        if (sat_val[DATA_WIDTH-1])
            sat_val = '0;
`endif
    end

    // Frame position of the pixel entering the output register: if the
    // current pixel leaves this cycle, the new one is one step further on.
    always_comb begin
        col_inc = col + 1'b1;
        row_inc = row;
        if (col == CW'(WIDTH-1)) begin
            col_inc = '0;
            row_inc = (row == RW'(HEIGHT-1)) ? '0 : row + 1'b1;
        end
        pos_col = hs ? col_inc : col;
        pos_row = hs ? row_inc : row;
    end

    // Valid shift register, output register and frame counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            data_out <= '0;
            last_out <= 1'b0;
            col      <= '0;
            row      <= '0;
        end else begin
            if (hs) begin
                col <= col_inc;
                row <= row_inc;
            end
            if (advance) begin
                vld_pipe <= {vld_pipe[STAGES-1:0], accept};
                last_out <= vld_pipe[STAGES-1] & (pos_col == CW'(WIDTH-1))
                                               & (pos_row == RW'(HEIGHT-1));
                if (vld_pipe[STAGES-1])
                    data_out <= sat_val;
            end
        end
    end

endmodule

// File: tb/tb_featuremap_conv2d_accum_param.sv
// Directed bench for featuremap_conv2d_accum_param (CHANNELS=8, 4x2 frame).
// A second instance with BIAS=0 covers the zero-bias saturation vectors.
module tb_featuremap_conv2d_accum_param;

    localparam int DW = 16;
    localparam int CH = 8;
    localparam int W  = 4;
    localparam int H  = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [CH*DW-1:0]  data_in;
    logic [CH-1:0]     fifo_empty;
    logic [CH-1:0]     mask = '0;
    logic              ready_in = 1'b1;
    logic              rdreq, valid_out, last_out;
    logic [DW-1:0]     data_out;
    logic              rdreq0, valid_out0, last_out0;
    logic [DW-1:0]     data_out0;

    always #5 clk = ~clk;

    featuremap_conv2d_accum_param #(
        .DATA_WIDTH(DW), .FRAC_BITS(8), .CHANNELS(CH), .BIAS(16'sh0080),
        .WIDTH(W), .HEIGHT(H)
    ) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .fifo_empty(fifo_empty),
        .rdreq(rdreq), .ready_in(ready_in), .valid_out(valid_out),
        .data_out(data_out), .last_out(last_out)
    );

    featuremap_conv2d_accum_param #(
        .DATA_WIDTH(DW), .FRAC_BITS(8), .CHANNELS(CH), .BIAS(16'sh0000),
        .WIDTH(W), .HEIGHT(H)
    ) dut0 (
        .clk(clk), .rst(rst), .data_in(data_in), .fifo_empty(fifo_empty),
        .rdreq(rdreq0), .ready_in(ready_in), .valid_out(valid_out0),
        .data_out(data_out0), .last_out(last_out0)
    );

    // Shared FIFO model: every channel carries the same sample value.
    logic [DW-1:0] src_data [0:255];
    int            src_wr = 0;
    int            src_rd = 0;

    assign data_in    = {CH{src_data[src_rd]}};
    assign fifo_empty = (src_rd == src_wr) ? '1 : mask;

    always @(posedge clk) if (rdreq) src_rd <= src_rd + 1;

    // Output log of accepted pixels (both instances advance in lockstep).
    logic [DW-1:0] out_data  [0:255];
    logic [DW-1:0] out_data0 [0:255];
    logic          out_last  [0:255];
    int            out_n = 0;

    always @(negedge clk) begin
        if (!rst && valid_out && ready_in) begin
            out_data[out_n]  <= data_out;
            out_data0[out_n] <= data_out0;
            out_last[out_n]  <= last_out;
            out_n            <= out_n + 1;
        end
    end

    int errors = 0;
    int checks = 0;

    function automatic logic [DW-1:0] exp_sum(input logic [DW-1:0] v);
        return (v << 3) + 16'h0080;
    endfunction

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic push(input logic [DW-1:0] v);
        src_data[src_wr] = v;
        src_wr++;
    endtask

    task automatic wait_outs(input int target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (out_n >= target) begin ok = 1'b1; break; end
            step(1);
        end
    endtask

    task automatic test_reset();
        bit ok;
        step(2);
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", valid_out); end
        checks++; if (data_out !== 16'h0000) begin errors++; $display("FAIL reset_data got=%h want=0000", data_out); end
        checks++; if (last_out !== 1'b0 || last_out0 !== 1'b0 || valid_out0 !== 1'b0) begin errors++; $display("FAIL reset_last got=%b/%b/%b want=0", last_out, last_out0, valid_out0); end
        push(16'h0010);
        step(1);
        checks++; if (rdreq !== 1'b0 || rdreq0 !== 1'b0) begin errors++; $display("FAIL reset_rdreq got=%b want=0", rdreq); end
        rst = 1'b0;
        #1;
        checks++; if (rdreq !== 1'b1) begin errors++; $display("FAIL post_reset_rdreq got=%b want=1", rdreq); end
        wait_outs(1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL reset_first_out timeout got=%0d want=1", out_n); end
        checks++; if (out_data[0] !== 16'h0100) begin errors++; $display("FAIL reset_first_data got=%h want=0100", out_data[0]); end
        checks++; if (out_data0[0] !== 16'h0080) begin errors++; $display("FAIL reset_first_data0 got=%h want=0080", out_data0[0]); end
        step(3);
    endtask

    task automatic test_basic();
        bit v4;
        push(16'h0100);
        #1;
        checks++; if (rdreq !== 1'b1) begin errors++; $display("FAIL basic_rdreq got=%b want=1", rdreq); end
        v4 = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            if (k == 4) v4 = valid_out;
        end
        checks++; if (v4 !== 1'b0) begin errors++; $display("FAIL basic_early_valid got=%b want=0", v4); end
        checks++; if (valid_out !== 1'b1 || valid_out0 !== 1'b1) begin errors++; $display("FAIL basic_latency got=%b want=1", valid_out); end
        checks++; if (data_out !== 16'h0880) begin errors++; $display("FAIL basic_sum got=%h want=0880", data_out); end
        checks++; if (data_out0 !== 16'h0800) begin errors++; $display("FAIL basic_sum_nobias got=%h want=0800", data_out0); end
        step(3);
    endtask

    task automatic test_saturation();
        bit ok;
        int base;
        logic [DW-1:0] vin [5] = '{16'h7000, 16'hFF00, 16'h8000, 16'h0FF0, 16'h0FEF};
`ifdef FEATUREMAP_RELU_EN
        logic [DW-1:0] e1 [5] = '{16'h7FFF, 16'h0000, 16'h0000, 16'h7FFF, 16'h7FF8};
        logic [DW-1:0] e0 [5] = '{16'h7FFF, 16'h0000, 16'h0000, 16'h7F80, 16'h7F78};
`else
        logic [DW-1:0] e1 [5] = '{16'h7FFF, 16'hF880, 16'h8000, 16'h7FFF, 16'h7FF8};
        logic [DW-1:0] e0 [5] = '{16'h7FFF, 16'hF800, 16'h8000, 16'h7F80, 16'h7F78};
`endif
        base = out_n;
        for (int i = 0; i < 5; i++) push(vin[i]);
        wait_outs(base + 5, ok);
        checks++; if (!ok) begin errors++; $display("FAIL sat_timeout got=%0d want=%0d", out_n - base, 5); end
        for (int i = 0; i < 5; i++) begin
            checks++; if (out_data[base+i] !== e1[i]) begin errors++; $display("FAIL sat_bias[%0d] got=%h want=%h", i, out_data[base+i], e1[i]); end
            checks++; if (out_data0[base+i] !== e0[i]) begin errors++; $display("FAIL sat_nobias[%0d] got=%h want=%h", i, out_data0[base+i], e0[i]); end
        end
        step(3);
    endtask

    task automatic test_empty_gating();
        bit ok, bad;
        int base;
        base = out_n;
        mask = 8'h08;
        for (int i = 1; i <= 6; i++) push(DW'(i));
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (rdreq !== 1'b0 || valid_out !== 1'b0) bad = 1'b1;
            step(1);
        end
        checks++; if (bad) begin errors++; $display("FAIL gate_rdreq got=1 want=0"); end
        mask = '0;
        wait_outs(base + 6, ok);
        step(8);
        checks++; if (!ok || out_n !== base + 6) begin errors++; $display("FAIL gate_count got=%0d want=6", out_n - base); end
        for (int i = 0; i < 6; i++) begin
            checks++; if (out_data[base+i] !== exp_sum(DW'(i+1))) begin errors++; $display("FAIL gate_order[%0d] got=%h want=%h", i, out_data[base+i], exp_sum(DW'(i+1))); end
        end
    endtask

    task automatic test_backpressure();
        bit ok, bad;
        int base;
        logic [DW-1:0] hold;
        base = out_n;
        for (int i = 0; i < 10; i++) push(DW'(16'h0010 + i));
        for (int i = 0; i < 50; i++) begin
            if (out_n >= base + 2) break;
            step(1);
        end
        ready_in = 1'b0;
        hold = data_out;
        #1;
        checks++; if (valid_out !== 1'b1 || hold !== exp_sum(16'h0012)) begin errors++; $display("FAIL bp_head got=%b/%h want=1/%h", valid_out, hold, exp_sum(16'h0012)); end
        bad = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (rdreq !== 1'b0 || valid_out !== 1'b1 || data_out !== hold) bad = 1'b1;
            step(1);
        end
        checks++; if (bad) begin errors++; $display("FAIL bp_hold got=%h want=%h", data_out, hold); end
        ready_in = 1'b1;
        wait_outs(base + 10, ok);
        step(8);
        checks++; if (!ok || out_n !== base + 10) begin errors++; $display("FAIL bp_count got=%0d want=10", out_n - base); end
        for (int i = 0; i < 10; i++) begin
            checks++; if (out_data[base+i] !== exp_sum(DW'(16'h0010 + i))) begin errors++; $display("FAIL bp_order[%0d] got=%h want=%h", i, out_data[base+i], exp_sum(DW'(16'h0010 + i))); end
        end
    endtask

    task automatic test_frame();
        bit ok;
        int base;
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        base = out_n;
        for (int i = 0; i < 24; i++) push(DW'(i));
        wait_outs(base + 24, ok);
        step(8);
        checks++; if (!ok) begin errors++; $display("FAIL frame_timeout got=%0d want=24", out_n - base); end
        for (int i = 0; i < 24; i++) begin
            checks++; if (out_last[base+i] !== ((i % 8) == 7)) begin errors++; $display("FAIL frame_last[%0d] got=%b want=%b", i + 1, out_last[base+i], (i % 8) == 7); end
        end
    endtask

    task automatic test_mid_reset();
        bit ok;
        int base, first, rd_after, post, rem;
        base  = out_n;
        first = src_wr;
        for (int i = 0; i < 20; i++) push(DW'(16'h0040 + i));
        for (int i = 0; i < 50; i++) begin
            if (out_n >= base + 3) break;
            step(1);
        end
        rst = 1'b1;
        #1;
        checks++; if (rdreq !== 1'b0) begin errors++; $display("FAIL mrst_rdreq got=%b want=0", rdreq); end
        step(1);
        checks++; if (valid_out !== 1'b0 || last_out !== 1'b0) begin errors++; $display("FAIL mrst_valid got=%b want=0", valid_out); end
        rst = 1'b0;
        rd_after = src_rd;
        post = out_n;
        rem  = src_wr - rd_after;
        checks++; if (post !== base + 3 || rem < 8) begin errors++; $display("FAIL mrst_outs got=%0d want=3 (remaining %0d)", post - base, rem); end
        wait_outs(post + rem, ok);
        step(8);
        checks++; if (!ok || out_n !== post + rem) begin errors++; $display("FAIL mrst_count got=%0d want=%0d", out_n - post, rem); end
        for (int k = 0; k < rem && k < 10; k++) begin
            checks++; if (out_data[post+k] !== exp_sum(DW'(16'h0040 + rd_after + k - first))) begin errors++; $display("FAIL mrst_data[%0d] got=%h want=%h", k, out_data[post+k], exp_sum(DW'(16'h0040 + rd_after + k - first))); end
            checks++; if (out_last[post+k] !== (k == 7)) begin errors++; $display("FAIL mrst_last[%0d] got=%b want=%b", k + 1, out_last[post+k], k == 7); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_empty_gating();
        test_backpressure();
        test_frame();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

endmodule
